// File: rtl/instr_trace_buffer.sv
// Instruction trace buffer: records {pc, ir[, flags]} for each fetch around a trigger, then replays the oldest entries first.
// Optional build macro TRACE_FLAGS_EN: when defined, condition flags are stored per entry and returned on rd_flags.
module instr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 16,
  parameter int IR_W      = 16,
  parameter int POST_TRIG = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [IR_W-1:0] fetch_ir,
  input  logic [3:0]      flags,
  input  logic            arm,
  input  logic [PC_W-1:0] trig_pc,
  input  logic            trig_force,
  input  logic            rd_en,
  output logic            rd_valid,
  output logic [PC_W-1:0] rd_pc,
  output logic [IR_W-1:0] rd_ir,
  output logic [3:0]      rd_flags,
  output logic            rd_last,
  output logic [1:0]      state_o,
  output logic            wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_INIT = (AW+1)'(POST_TRIG);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic [AW:0]   post_cnt;
  logic          capture;
  logic          trigger;
  logic          pop;

  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [IR_W-1:0] mem_ir [DEPTH];
`ifdef TRACE_FLAGS_EN
  logic [3:0]      mem_fl [DEPTH];
`else
  logic            unused_flags;
  assign unused_flags = ^flags;
  assign rd_flags     = 4'b0;
`endif

  // Oldest entry sits fill slots behind the write pointer; popping walks it forward.
  assign rd_ptr  = wr_ptr - fill[AW-1:0];
  assign state_o = state;

  always_comb begin
    capture = !reset && fetch_valid && (state == ARMED || state == POST);
    trigger = (state == ARMED) && (trig_force || (fetch_valid && fetch_pc == trig_pc));
    pop     = (state == DONE) && rd_en && !rd_valid && (fill != '0);
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_pc[wr_ptr] <= fetch_pc;
      mem_ir[wr_ptr] <= fetch_ir;
`ifdef TRACE_FLAGS_EN
      mem_fl[wr_ptr] <= flags;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      post_cnt <= '0;
      wrapped  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_pc    <= '0;
      rd_ir    <= '0;
`ifdef TRACE_FLAGS_EN
      rd_flags <= 4'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= ARMED;
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            wrapped  <= 1'b0;
          end
        end
        ARMED, POST: begin
          if (capture) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (fill == FILL_MAX) wrapped <= 1'b1;
            else                  fill    <= fill + CNT_ONE;
          end
          if (trigger) begin
            if (POST_TRIG == 0) begin
              state <= DONE;
            end else begin
              state    <= POST;
              post_cnt <= POST_INIT;
            end
          end else if (state == POST && capture) begin
            post_cnt <= post_cnt - CNT_ONE;
            if (post_cnt == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          // Leave once the final entry has been presented, or on a pop of an empty buffer.
          if (rd_valid && rd_last) begin
            state <= IDLE;
          end else if (rd_en && !rd_valid && fill == '0) begin
            state <= IDLE;
          end else if (pop) begin
            rd_valid <= 1'b1;
            rd_last  <= (fill == CNT_ONE);
            fill     <= fill - CNT_ONE;
            rd_pc    <= mem_pc[rd_ptr];
            rd_ir    <= mem_ir[rd_ptr];
`ifdef TRACE_FLAGS_EN
            rd_flags <= mem_fl[rd_ptr];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Self-checking bench for instr_trace_buffer: three instances (POST_TRIG 8, 4, 0) share stimulus;
// a small capture model fills a scoreboard queue that readout pops and compares.
module tb_instr_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, arm, trig_force, rd_en;
  logic [15:0] fetch_pc, fetch_ir, trig_pc;
  logic [3:0]  flags;

  logic        rd_valid_o [3];
  logic [15:0] rd_pc_o    [3];
  logic [15:0] rd_ir_o    [3];
  logic [3:0]  rd_flags_o [3];
  logic        rd_last_o  [3];
  logic [1:0]  state_o_o  [3];
  logic        wrapped_o  [3];

  always #5 clk = ~clk;

  instr_trace_buffer #(.DEPTH(16), .PC_W(16), .IR_W(16), .POST_TRIG(8)) u_pt8 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ir(fetch_ir),
    .flags(flags), .arm(arm), .trig_pc(trig_pc), .trig_force(trig_force), .rd_en(rd_en),
    .rd_valid(rd_valid_o[0]), .rd_pc(rd_pc_o[0]), .rd_ir(rd_ir_o[0]), .rd_flags(rd_flags_o[0]),
    .rd_last(rd_last_o[0]), .state_o(state_o_o[0]), .wrapped(wrapped_o[0]));

  instr_trace_buffer #(.DEPTH(16), .PC_W(16), .IR_W(16), .POST_TRIG(4)) u_pt4 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ir(fetch_ir),
    .flags(flags), .arm(arm), .trig_pc(trig_pc), .trig_force(trig_force), .rd_en(rd_en),
    .rd_valid(rd_valid_o[1]), .rd_pc(rd_pc_o[1]), .rd_ir(rd_ir_o[1]), .rd_flags(rd_flags_o[1]),
    .rd_last(rd_last_o[1]), .state_o(state_o_o[1]), .wrapped(wrapped_o[1]));

  instr_trace_buffer #(.DEPTH(16), .PC_W(16), .IR_W(16), .POST_TRIG(0)) u_pt0 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ir(fetch_ir),
    .flags(flags), .arm(arm), .trig_pc(trig_pc), .trig_force(trig_force), .rd_en(rd_en),
    .rd_valid(rd_valid_o[2]), .rd_pc(rd_pc_o[2]), .rd_ir(rd_ir_o[2]), .rd_flags(rd_flags_o[2]),
    .rd_last(rd_last_o[2]), .state_o(state_o_o[2]), .wrapped(wrapped_o[2]));

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [3:0]  fl;
  } ent_t;

  ent_t sb[$];
  int   m_state, m_post;
  bit   m_wrapped;
  int   pt_of [3] = '{8, 4, 0};
  int   sel;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] expfl(input logic [3:0] f);
`ifdef TRACE_FLAGS_EN
    return f;
`else
    return f & 4'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_state   = 0;
    m_post    = 0;
    m_wrapped = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    if (m_state == 0) begin
      model_clear();
      m_state = 1;
    end
    tick();
    arm = 1'b0;
  endtask

  task automatic model_trigger();
    if (pt_of[sel] == 0) m_state = 3;
    else begin
      m_state = 2;
      m_post  = pt_of[sel];
    end
  endtask

  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] ir, input logic [3:0] fl, input bit frc);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_ir = ir; flags = fl; trig_force = frc;
    if (m_state == 1 || m_state == 2) begin
      if (sb.size() == 16) begin
        void'(sb.pop_front());
        m_wrapped = 1;
      end
      sb.push_back('{pc: pc, ir: ir, fl: fl});
    end
    if (m_state == 1 && (pc == trig_pc || frc)) model_trigger();
    else if (m_state == 2) begin
      m_post--;
      if (m_post == 0) m_state = 3;
    end
    tick();
    fetch_valid = 1'b0; trig_force = 1'b0;
  endtask

  task automatic do_force();
    trig_force = 1'b1;
    if (m_state == 1) model_trigger();
    tick();
    trig_force = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_o_o[i] !== 2'd0 || rd_valid_o[i] !== 1'b0 || rd_last_o[i] !== 1'b0 || wrapped_o[i] !== 1'b0 ||
          rd_pc_o[i] !== 16'h0 || rd_ir_o[i] !== 16'h0 || rd_flags_o[i] !== 4'h0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got st=%0d v=%0b last=%0b wr=%0b pc=%h ir=%h fl=%h expected all zero",
                 i, state_o_o[i], rd_valid_o[i], rd_last_o[i], wrapped_o[i], rd_pc_o[i], rd_ir_o[i], rd_flags_o[i]);
      end
    end
  endtask

  task automatic test_capture(input int s);
    ent_t e;
    sel = s;
    do_reset();
    trig_pc = 16'h0006;
    do_arm();
    checks++;
    if (state_o_o[sel] !== 2'd1) begin
      errors++; $display("FAIL cap_armed inst=%0d got %0d expected 1", sel, state_o_o[sel]);
    end
    for (int k = 0; k < 24 && m_state != 3; k++) begin
      do_fetch(16'(2 * k), 16'hA000 + 16'(k), 4'(k), 1'b0);
      checks++;
      if (state_o_o[sel] !== 2'(m_state)) begin
        errors++; $display("FAIL cap_state inst=%0d fetch=%0d got %0d expected %0d", sel, k, state_o_o[sel], m_state);
      end
    end
    do_fetch(16'h00F0, 16'hDEAD, 4'hF, 1'b0);
    checks++;
    if (state_o_o[sel] !== 2'd3 || wrapped_o[sel] !== 1'b0) begin
      errors++; $display("FAIL cap_done inst=%0d got st=%0d wr=%0b expected st=3 wr=0", sel, state_o_o[sel], wrapped_o[sel]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++;
      if (rd_valid_o[sel] !== 1'b1 || rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir ||
          rd_flags_o[sel] !== expfl(e.fl) || rd_last_o[sel] !== (sb.size() == 0)) begin
        errors++;
        $display("FAIL cap_pop inst=%0d got v=%0b pc=%h ir=%h fl=%h last=%0b expected pc=%h ir=%h fl=%h last=%0b",
                 sel, rd_valid_o[sel], rd_pc_o[sel], rd_ir_o[sel], rd_flags_o[sel], rd_last_o[sel],
                 e.pc, e.ir, expfl(e.fl), (sb.size() == 0));
      end
      tick();
    end
    checks++;
    if (state_o_o[sel] !== 2'd0) begin
      errors++; $display("FAIL cap_idle inst=%0d got %0d expected 0", sel, state_o_o[sel]);
    end
  endtask

  task automatic test_wrap();
    ent_t e;
    sel = 1;
    do_reset();
    trig_pc = 16'd40;
    do_arm();
    for (int k = 0; k < 30; k++) do_fetch(16'(2 * k), 16'h5000 + 16'(k), 4'(k), 1'b0);
    checks++;
    if (state_o_o[sel] !== 2'd3 || wrapped_o[sel] !== 1'(m_wrapped)) begin
      errors++; $display("FAIL wrap_done got st=%0d wr=%0b expected st=3 wr=%0b", state_o_o[sel], wrapped_o[sel], m_wrapped);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++;
      if (rd_valid_o[sel] !== 1'b1 || rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir ||
          rd_flags_o[sel] !== expfl(e.fl) || rd_last_o[sel] !== (sb.size() == 0)) begin
        errors++;
        $display("FAIL wrap_pop got v=%0b pc=%h ir=%h fl=%h last=%0b expected pc=%h ir=%h fl=%h last=%0b",
                 rd_valid_o[sel], rd_pc_o[sel], rd_ir_o[sel], rd_flags_o[sel], rd_last_o[sel],
                 e.pc, e.ir, expfl(e.fl), (sb.size() == 0));
      end
      tick();
    end
    checks++;
    if (state_o_o[sel] !== 2'd0) begin
      errors++; $display("FAIL wrap_idle got %0d expected 0", state_o_o[sel]);
    end
  endtask

  task automatic test_force_zero();
    ent_t e;
    sel = 2;
    do_reset();
    trig_pc = 16'hFFFF;
    do_arm();
    do_fetch(16'h0100, 16'hBEEF, 4'b1010, 1'b1);
    checks++;
    if (state_o_o[sel] !== 2'd3) begin
      errors++; $display("FAIL fz_done got %0d expected 3", state_o_o[sel]);
    end
    e = sb.pop_front();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if (rd_valid_o[sel] !== 1'b1 || rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir ||
        rd_flags_o[sel] !== expfl(e.fl) || rd_last_o[sel] !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL fz_pop got v=%0b pc=%h ir=%h fl=%h last=%0b expected pc=%h ir=%h fl=%h last=1",
               rd_valid_o[sel], rd_pc_o[sel], rd_ir_o[sel], rd_flags_o[sel], rd_last_o[sel], e.pc, e.ir, expfl(e.fl));
    end
    tick();
    checks++;
    if (state_o_o[sel] !== 2'd0 || rd_valid_o[sel] !== 1'b0) begin
      errors++; $display("FAIL fz_idle got st=%0d v=%0b expected st=0 v=0", state_o_o[sel], rd_valid_o[sel]);
    end
    // Trigger without any capture leaves an empty buffer in DONE.
    do_arm();
    do_force();
    checks++;
    if (state_o_o[sel] !== 2'd3) begin
      errors++; $display("FAIL fz_empty_done got %0d expected 3", state_o_o[sel]);
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    m_state = 0;
    checks++;
    if (state_o_o[sel] !== 2'd0 || rd_valid_o[sel] !== 1'b0) begin
      errors++; $display("FAIL fz_empty_pop got st=%0d v=%0b expected st=0 v=0", state_o_o[sel], rd_valid_o[sel]);
    end
    arm = 1'b1; trig_force = 1'b1;
    tick();
    arm = 1'b0; trig_force = 1'b0;
    model_clear(); m_state = 1;
    checks++;
    if (state_o_o[sel] !== 2'd1) begin
      errors++; $display("FAIL fz_arm_force got %0d expected 1", state_o_o[sel]);
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    sel = 1;
    do_reset();
    trig_pc = 16'hFFFF;
    do_arm();
    for (int k = 0; k < 20; k++) do_fetch(16'h0100 + 16'(2 * k), 16'h7000 + 16'(k), 4'(k), 1'b0);
    do_force();
    do_fetch(16'h0180, 16'h7100, 4'h3, 1'b0);
    checks++;
    if (state_o_o[sel] !== 2'd2 || wrapped_o[sel] !== 1'b1) begin
      errors++; $display("FAIL rm_post got st=%0d wr=%0b expected st=2 wr=1", state_o_o[sel], wrapped_o[sel]);
    end
    reset = 1'b1; fetch_valid = 1'b1; arm = 1'b1;
    tick();
    reset = 1'b0; fetch_valid = 1'b0; arm = 1'b0;
    model_clear();
    checks++;
    if (state_o_o[sel] !== 2'd0 || wrapped_o[sel] !== 1'b0 || rd_valid_o[sel] !== 1'b0) begin
      errors++; $display("FAIL rm_post_reset got st=%0d wr=%0b v=%0b expected 0 0 0", state_o_o[sel], wrapped_o[sel], rd_valid_o[sel]);
    end
    trig_pc = 16'h0224;
    do_arm();
    for (int k = 0; k < 40 && m_state != 3; k++) do_fetch(16'h0200 + 16'(2 * k), 16'h8000 + 16'(k), 4'(k), 1'b0);
    for (int j = 0; j < 2; j++) begin
      e = sb.pop_front();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++;
      if (rd_valid_o[sel] !== 1'b1 || rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir || rd_last_o[sel] !== 1'b0) begin
        errors++;
        $display("FAIL rm_pop got v=%0b pc=%h ir=%h last=%0b expected pc=%h ir=%h last=0",
                 rd_valid_o[sel], rd_pc_o[sel], rd_ir_o[sel], rd_last_o[sel], e.pc, e.ir);
      end
      tick();
    end
    rd_en = 1'b1; reset = 1'b1;
    tick();
    rd_en = 1'b0; reset = 1'b0;
    model_clear();
    checks++;
    if (state_o_o[sel] !== 2'd0 || rd_valid_o[sel] !== 1'b0 || wrapped_o[sel] !== 1'b0) begin
      errors++; $display("FAIL rm_read_reset got st=%0d v=%0b wr=%0b expected 0 0 0", state_o_o[sel], rd_valid_o[sel], wrapped_o[sel]);
    end
    trig_pc = 16'h0300;
    do_arm();
    for (int k = 0; k < 10 && m_state != 3; k++) do_fetch(16'h0300 + 16'(2 * k), 16'h9000 + 16'(k), 4'(k), 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++;
      if (rd_valid_o[sel] !== 1'b1 || rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir ||
          rd_flags_o[sel] !== expfl(e.fl) || rd_last_o[sel] !== (sb.size() == 0)) begin
        errors++;
        $display("FAIL rm_fresh_pop got v=%0b pc=%h ir=%h fl=%h last=%0b expected pc=%h ir=%h fl=%h last=%0b",
                 rd_valid_o[sel], rd_pc_o[sel], rd_ir_o[sel], rd_flags_o[sel], rd_last_o[sel],
                 e.pc, e.ir, expfl(e.fl), (sb.size() == 0));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int   n;
    int   pulses;
    sel = 0;
    do_reset();
    trig_pc = 16'h0040;
    do_arm();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if (rd_valid_o[sel] !== 1'b0 || state_o_o[sel] !== 2'd1) begin
      errors++; $display("FAIL b2b_rd_armed got v=%0b st=%0d expected v=0 st=1", rd_valid_o[sel], state_o_o[sel]);
    end
    do_fetch(16'h003E, 16'hC000, 4'b1010, 1'b0);
    do_arm();
    for (int k = 0; k < 20 && m_state != 3; k++) do_fetch(16'h0040 + 16'(2 * k), 16'hC100 + 16'(k), 4'b1010, 1'b0);
    n = sb.size();
    pulses = 0;
    rd_en = 1'b1;
    for (int t = 0; t < 2 * n; t++) begin
      tick();
      checks++;
      if (rd_valid_o[sel] !== ((t % 2) == 0)) begin
        errors++; $display("FAIL b2b_strobe t=%0d got %0b expected %0b", t, rd_valid_o[sel], ((t % 2) == 0));
      end
      if (rd_valid_o[sel] === 1'b1 && sb.size() > 0) begin
        pulses++;
        e = sb.pop_front();
        checks++;
        if (rd_pc_o[sel] !== e.pc || rd_ir_o[sel] !== e.ir || rd_flags_o[sel] !== expfl(e.fl) ||
            rd_last_o[sel] !== (sb.size() == 0)) begin
          errors++;
          $display("FAIL b2b_pop got pc=%h ir=%h fl=%h last=%0b expected pc=%h ir=%h fl=%h last=%0b",
                   rd_pc_o[sel], rd_ir_o[sel], rd_flags_o[sel], rd_last_o[sel], e.pc, e.ir, expfl(e.fl), (sb.size() == 0));
        end
      end
    end
    rd_en = 1'b0;
    checks++;
    if (pulses != n || state_o_o[sel] !== 2'd0) begin
      errors++; $display("FAIL b2b_count got pulses=%0d st=%0d expected pulses=%0d st=0", pulses, state_o_o[sel], n);
    end
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; arm = 1'b0; trig_force = 1'b0; rd_en = 1'b0;
    fetch_pc = '0; fetch_ir = '0; trig_pc = '0; flags = '0;
    sel = 0;
    model_clear();
    test_reset();
    test_capture(0);
    test_capture(1);
    test_wrap();
    test_force_zero();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
